modmult_scheduler: RTL and testbench

- Shares one fully pipelined `modular_mult` instance among NUM_REQ requesters (NTT butterfly lanes, twiddle pre-scalers).
- Arbitration is round-robin with zero-bubble grants.
- A tag delay line matching the multiplier latency returns each product with its requester ID.
- Owns the modulus register `q`; updates it safely by draining the pipeline first.

---
 rtl/modmult_pkg.sv | 20 ++
 rtl/modular_mult.sv | 33 +++
 rtl/rr_arbiter.sv | 41 ++++
 rtl/modmult_scheduler.sv | 117 +++++++++++
 tb/tb_modmult_scheduler.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/modmult_pkg.sv
// Shared types for the modular multiplier scheduler.
// Widths, default modulus, FSM states and pipeline tags.
package modmult_pkg;

   localparam int W = 28;
   localparam logic [W-1:0] Q_INIT = 28'd268369921;
   localparam int ID_W = 3;

   typedef enum logic [1:0] {
      RUN,
      DRAIN,
      LOAD
   } state_t;

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
   } tag_t;

endpackage

// File: rtl/modular_mult.sv
// Fully pipelined (a*b) mod q, LAT cycles from inputs to out.
// Datapath stages carry no reset; validity is tracked outside.
module modular_mult #(
   parameter int W   = 28,
   parameter int LAT = 7
) (
   input  logic         clk,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [W-1:0] q,
   output logic [W-1:0] out
);

   logic [2*W-1:0] prod;
   logic [W-1:0]   r;
   logic [W-1:0]   pipe [LAT];

   // reduce the full product against the current modulus
   always_comb begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      r    = W'(prod % {{W{1'b0}}, q});
   end

   // delay the reduced value to the advertised latency
   always_ff @(posedge clk) begin
      pipe[0] <= r;
      for (int i = 1; i < LAT; i++)
         pipe[i] <= pipe[i-1];
   end

   assign out = pipe[LAT-1];

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from ptr+1.
// Pointer follows the last granted index.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [PW-1:0]      gnt_idx,
   output logic               gnt_any
);

   logic [PW-1:0] ptr;

   // first valid requester after ptr, wrapping around
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!gnt_any && req[PW'((int'(ptr) + i) % NUM_REQ)]) begin
            gnt_any = 1'b1;
            gnt_idx = PW'((int'(ptr) + i) % NUM_REQ);
         end
      end
      if (!en)
         gnt_any = 1'b0;
      gnt = gnt_any ? (NUM_REQ'(1) << gnt_idx) : '0;
   end

   // remember the last winner so it goes to the back of the line
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= PW'(NUM_REQ - 1);
      else if (gnt_any)
         ptr <= gnt_idx;
   end

endmodule

// File: rtl/modmult_scheduler.sv
// Shares one pipelined modular multiplier among NUM_REQ requesters.
// Tags products with requester IDs; drains before changing q.
module modmult_scheduler #(
   parameter int NUM_REQ  = 4,
   parameter int W        = modmult_pkg::W,
   parameter int MULT_LAT = 7,
   parameter logic [W-1:0] Q_INIT = W'(modmult_pkg::Q_INIT),
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW = $clog2(MULT_LAT + 1)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0][W-1:0] req_a,
   input  logic [NUM_REQ-1:0][W-1:0] req_b,
   output logic                      res_valid,
   output logic [IW-1:0]             res_id,
   output logic [W-1:0]              res_data,
   input  logic                      q_wr,
   input  logic [W-1:0]              q_wdata,
   output logic                      q_busy,
   output logic [W-1:0]              q_cur
);

   import modmult_pkg::*;

   state_t        state;
   logic [W-1:0]  q_pend;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   tag_t          tags [MULT_LAT];
   logic          gnt_any;
   logic [IW-1:0] gnt_idx;
   logic [W-1:0]  mul_out;
   logic          retire;

   rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (state == RUN),
      .req    (req_valid),
      .gnt    (req_ready),
      .gnt_idx(gnt_idx),
      .gnt_any(gnt_any)
   );

   modular_mult #(
      .W  (W),
      .LAT(MULT_LAT)
   ) u_mult (
      .clk(clk),
      .a  (req_a[gnt_idx]),
      .b  (req_b[gnt_idx]),
      .q  (q_cur),
      .out(mul_out)
   );

   assign retire    = tags[MULT_LAT-1].valid;
   assign res_valid = retire;
   assign res_id    = IW'(tags[MULT_LAT-1].id);
   assign res_data  = retire ? mul_out : '0;
   assign cnt_nxt   = cnt + CW'(gnt_any) - CW'(retire);

   // tag line shadows the multiplier pipeline, one slot per cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MULT_LAT; i++)
            tags[i] <= '0;
      end else begin
         tags[0] <= '{valid: gnt_any, id: ID_W'(gnt_idx)};
         for (int i = 1; i < MULT_LAT; i++)
            tags[i] <= tags[i-1];
      end
   end

   // products currently inside the multiplier
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_nxt;
   end

   // modulus update: stop issuing, wait for empty pipe, swap q
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= RUN;
         q_cur  <= Q_INIT;
         q_pend <= Q_INIT;
         q_busy <= 1'b0;
      end else begin
         unique case (state)
            RUN: begin
               if (q_wr && !q_busy) begin
                  q_pend <= q_wdata;
                  q_busy <= 1'b1;
                  state  <= DRAIN;
               end
            end
            DRAIN: begin
               if (cnt_nxt == '0)
                  state <= LOAD;
            end
            LOAD: begin
               q_cur  <= q_pend;
               q_busy <= 1'b0;
               state  <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_modmult_scheduler.sv
// Scoreboard bench for modmult_scheduler.
// Grants push expected results; a monitor pops on res_valid.
module tb_modmult_scheduler;

   localparam int N   = 4;
   localparam int W   = 28;
   localparam int LAT = 7;
   localparam logic [W-1:0] QI = 28'd268369921;

   logic                clk = 1'b0;
   logic                rst;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_ready;
   logic [N-1:0][W-1:0] req_a;
   logic [N-1:0][W-1:0] req_b;
   logic                res_valid;
   logic [1:0]          res_id;
   logic [W-1:0]        res_data;
   logic                q_wr;
   logic [W-1:0]        q_wdata;
   logic                q_busy;
   logic [W-1:0]        q_cur;

   typedef struct {
      int     id;
      longint data;
      int     cyc;
   } exp_t;

   exp_t   sb [$];
   exp_t   e;
   int     gnt_log [$];
   int     res_cyc [$];
   int     tests = 0;
   int     fails = 0;
   int     cyc = 0;
   int     res_count = 0;
   int     last_id = -1;
   longint last_data = -1;
   longint tb_q = longint'(QI);

   modmult_scheduler #(
      .NUM_REQ (N),
      .W       (W),
      .MULT_LAT(LAT),
      .Q_INIT  (QI)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_a    (req_a),
      .req_b    (req_b),
      .res_valid(res_valid),
      .res_id   (res_id),
      .res_data (res_data),
      .q_wr     (q_wr),
      .q_wdata  (q_wdata),
      .q_busy   (q_busy),
      .q_cur    (q_cur)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc = cyc + 1;

   task automatic check(input string name, input longint act,
                        input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // grant recorder and result monitor, sampled mid-cycle
   always @(negedge clk) begin
      if (!rst) begin
         if (req_ready != '0) begin
            check("ready_onehot", $countones(req_ready), 1);
            for (int i = 0; i < N; i++) begin
               if (req_ready[i]) begin
                  check("ready_has_valid", req_valid[i], 1);
                  gnt_log.push_back(i);
                  sb.push_back('{i,
                     (longint'(req_a[i]) * longint'(req_b[i])) % tb_q,
                     cyc + LAT});
               end
            end
         end
         if (res_valid) begin
            res_count++;
            res_cyc.push_back(cyc);
            last_id   = int'(res_id);
            last_data = longint'(res_data);
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_res: id %0d data %0d, none expected",
                        res_id, res_data);
            end else begin
               e = sb.pop_front();
               check("res_id", res_id, e.id);
               check("res_data", res_data, e.data);
               check("res_cycle", cyc, e.cyc);
            end
         end
      end
   end

   int n0;
   int errs;
   int cnt4 [N];
   int exp4 [8] = '{3, 1, 3, 1, 3, 1, 3, 1};

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      q_wr      = 1'b0;
      q_wdata   = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_data", res_data, 0);
      check("rst_q_busy", q_busy, 0);
      check("rst_q_cur", q_cur, QI);
      rst = 1'b0;
      step();

      // single product 2*3 on requester 0
      n0 = res_count;
      req_valid = 4'b0001;
      req_a[0] = 28'd2;
      req_b[0] = 28'd3;
      step();
      req_valid = '0;
      repeat (10) step();
      check("t1_count", res_count, n0 + 1);
      check("t1_data", last_data, 6);
      check("t1_id", last_id, 0);

      // (q-1)^2 mod q on requester 2
      n0 = res_count;
      req_valid = 4'b0100;
      req_a[2] = QI - 28'd1;
      req_b[2] = QI - 28'd1;
      step();
      req_valid = '0;
      repeat (10) step();
      check("t2_count", res_count, n0 + 1);
      check("t2_data", last_data, 1);
      check("t2_id", last_id, 2);

      // all requesters streaming for 40 cycles
      gnt_log.delete();
      res_cyc.delete();
      req_valid = 4'hf;
      for (int k = 0; k < 40; k++) begin
         for (int j = 0; j < N; j++) begin
            req_a[j] = W'(k * 4 + j + 1);
            req_b[j] = W'(1000 + 3 * k + j);
         end
         step();
      end
      req_valid = '0;
      repeat (10) step();
      check("t3_grants", gnt_log.size(), 40);
      check("t3_res", res_cyc.size(), 40);
      if (gnt_log.size() == 40) begin
         check("t3_first", gnt_log[0], 3);
         errs = 0;
         for (int i = 0; i < N; i++) cnt4[i] = 0;
         for (int i = 0; i < 40; i++) begin
            if (gnt_log[i] != (3 + i) % 4) errs++;
            cnt4[gnt_log[i]]++;
         end
         check("t3_order", errs, 0);
         for (int i = 0; i < N; i++)
            check("t3_per_req", cnt4[i], 10);
      end
      if (res_cyc.size() == 40) begin
         errs = 0;
         for (int i = 1; i < 40; i++)
            if (res_cyc[i] != res_cyc[i-1] + 1) errs++;
         check("t3_no_gaps", errs, 0);
      end

      // only requesters 1 and 3
      gnt_log.delete();
      req_valid = 4'b1010;
      req_a[1] = 28'd11; req_b[1] = 28'd13;
      req_a[3] = 28'd17; req_b[3] = 28'd19;
      repeat (8) step();
      req_valid = '0;
      repeat (10) step();
      check("t4_grants", gnt_log.size(), 8);
      if (gnt_log.size() == 8)
         for (int i = 0; i < 8; i++)
            check("t4_order", gnt_log[i], exp4[i]);

      // modulus change to 97 while streaming
      req_valid = 4'hf;
      for (int j = 0; j < N; j++) begin
         req_a[j] = W'(j + 5);
         req_b[j] = W'(j + 11);
      end
      repeat (3) step();
      q_wr = 1'b1;
      q_wdata = 28'd97;
      step();
      q_wr = 1'b0;
      check("t5_ready_drop", req_ready, 0);
      check("t5_busy", q_busy, 1);
      req_valid = '0;
      for (int k = 0; k < 30 && q_busy; k++) begin
         check("t5_drain_ready", req_ready, 0);
         check("t5_drain_q", q_cur, QI);
         step();
      end
      check("t5_busy_fall", q_busy, 0);
      check("t5_drained", sb.size(), 0);
      check("t5_q_cur", q_cur, 97);
      tb_q = 97;
      n0 = res_count;
      req_valid = 4'b0001;
      req_a[0] = 28'd50;
      req_b[0] = 28'd2;
      step();
      req_valid = '0;
      repeat (10) step();
      check("t5_count", res_count, n0 + 1);
      check("t5_data", last_data, 3);
      check("t5_id", last_id, 0);

      // reset while four products are in flight
      gnt_log.delete();
      req_valid = 4'hf;
      for (int j = 0; j < N; j++) begin
         req_a[j] = W'(j + 2);
         req_b[j] = W'(j + 3);
      end
      repeat (4) step();
      req_valid = '0;
      check("t6_grants", gnt_log.size(), 4);
      #2 rst = 1'b1;
      sb.delete();
      n0 = res_count;
      #1;
      check("t6_rst_q_cur", q_cur, QI);
      check("t6_rst_busy", q_busy, 0);
      check("t6_rst_res_valid", res_valid, 0);
      #9 rst = 1'b0;
      tb_q = longint'(QI);
      repeat (12) step();
      check("t6_no_results", res_count, n0);
      gnt_log.delete();
      req_valid = 4'hf;
      step();
      req_valid = '0;
      check("t6_one_grant", gnt_log.size(), 1);
      if (gnt_log.size() >= 1)
         check("t6_grant_req0", gnt_log[0], 0);
      repeat (10) step();
      check("t6_sb_empty", sb.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
